// File: rtl/adc_spi_init.sv
// adc_spi_init
//   Writes a table of NUM_REGS configuration words to an ADC over a
//   write-only SPI link once the MMCM has held lock for LOCK_WAIT cycles.
//   Words come from an external synchronous ROM and are shifted out MSB first.
//
// Ports
//   sys_clk    : sole clock, all logic on its rising edge
//   sys_rst    : synchronous active-high reset
//   locked     : MMCM lock status (sys_clk domain)
//   start      : one-cycle pulse, re-runs the table from DONE, clears err in IDLE
//   cfg_addr   : table index to the config ROM
//   cfg_data   : ROM word, valid one cycle after cfg_addr changes
//   spi_csn    : ADC chip select, active low
//   spi_sclk   : SPI clock, idles low, ADC samples on its rising edge
//   spi_sdata  : SPI data, changes only on spi_sclk falling, 0 while deselected
//   busy       : lock qualification through the gap after the last word
//   init_done  : all words sent; cleared by a new run or lock loss
//   err        : sticky flag, lock lost while a run was transferring
module adc_spi_init #(
    parameter int WORD_W    = 24,
    parameter int NUM_REGS  = 8,
    parameter int SCLK_DIV  = 2,
    parameter int LOCK_WAIT = 1024,
    parameter int CS_GAP    = 4,
    localparam int AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              locked,
    input  logic              start,
    output logic [AW-1:0]     cfg_addr,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              spi_csn,
    output logic              spi_sclk,
    output logic              spi_sdata,
    output logic              busy,
    output logic              init_done,
    output logic              err
);

    localparam int LW   = $clog2(LOCK_WAIT + 1);
    localparam int PMAX = (SCLK_DIV > CS_GAP) ? SCLK_DIV : CS_GAP;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int BW   = $clog2(WORD_W + 1);

    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_WAIT - 1);
    localparam logic [PW-1:0] DIV_LAST  = PW'(SCLK_DIV - 1);
    localparam logic [PW-1:0] GAP_LAST  = PW'(CS_GAP - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_LOCK, FETCH, SHIFT, TAIL, GAP, DONE
    } state_t;

    state_t            state;
    logic [LW-1:0]     lock_cnt;
    logic [PW-1:0]     ph_cnt;     // shared by ROM wait, SCLK half-period, TAIL and GAP
    logic [BW-1:0]     bit_cnt;
    logic [WORD_W-1:0] shreg;      // MSB is always the bit currently on spi_sdata

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            lock_cnt  <= '0;
            ph_cnt    <= '0;
            bit_cnt   <= '0;
            cfg_addr  <= '0;
            spi_csn   <= 1'b1;
            spi_sclk  <= 1'b0;
            spi_sdata <= 1'b0;
            busy      <= 1'b0;
            init_done <= 1'b0;
            err       <= 1'b0;
        end else if ((state inside {FETCH, SHIFT, TAIL, GAP}) && !locked) begin
            // Lock lost mid-run: drop the frame and requalify from entry 0.
            state     <= WAIT_LOCK;
            lock_cnt  <= '0;
            ph_cnt    <= '0;
            bit_cnt   <= '0;
            cfg_addr  <= '0;
            spi_csn   <= 1'b1;
            spi_sclk  <= 1'b0;
            spi_sdata <= 1'b0;
            err       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start)
                        err <= 1'b0;
                    if (locked) begin
                        state    <= WAIT_LOCK;
                        lock_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end

                WAIT_LOCK: begin
                    if (!locked) begin
                        lock_cnt <= '0;
                    end else if (lock_cnt == LOCK_LAST) begin
                        state    <= FETCH;
                        cfg_addr <= '0;
                        ph_cnt   <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end

                // First cycle lets the ROM register the new address, second captures.
                FETCH: begin
                    if (ph_cnt == '0) begin
                        ph_cnt <= PW'(1);
                    end else begin
                        state     <= SHIFT;
                        shreg     <= cfg_data;
                        spi_sdata <= cfg_data[WORD_W-1];
                        spi_csn   <= 1'b0;
                        spi_sclk  <= 1'b0;
                        ph_cnt    <= '0;
                        bit_cnt   <= '0;
                    end
                end

                SHIFT: begin
                    if (ph_cnt != DIV_LAST) begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end else begin
                        ph_cnt <= '0;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                        end else begin
                            spi_sclk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state <= TAIL;
                            end else begin
                                bit_cnt   <= bit_cnt + 1'b1;
                                shreg     <= {shreg[WORD_W-2:0], 1'b0};
                                spi_sdata <= shreg[WORD_W-2];
                            end
                        end
                    end
                end

                TAIL: begin
                    if (ph_cnt != DIV_LAST) begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end else begin
                        ph_cnt    <= '0;
                        spi_csn   <= 1'b1;
                        spi_sdata <= 1'b0;
                        state     <= GAP;
                    end
                end

                GAP: begin
                    if (ph_cnt != GAP_LAST) begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end else begin
                        ph_cnt <= '0;
                        if (cfg_addr == ADDR_LAST) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            init_done <= 1'b1;
                        end else begin
                            cfg_addr <= cfg_addr + 1'b1;
                            state    <= FETCH;
                        end
                    end
                end

                DONE: begin
                    // Lock loss re-initialises automatically and keeps err as is.
                    if (!locked) begin
                        state     <= WAIT_LOCK;
                        lock_cnt  <= '0;
                        busy      <= 1'b1;
                        init_done <= 1'b0;
                    end else if (start) begin
                        state     <= WAIT_LOCK;
                        lock_cnt  <= '0;
                        busy      <= 1'b1;
                        init_done <= 1'b0;
                        err       <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_init.sv
module tb_adc_spi_init;

    localparam int WORD_W    = 24;
    localparam int NUM_REGS  = 4;
    localparam int SCLK_DIV  = 2;
    localparam int LOCK_WAIT = 16;
    localparam int CS_GAP    = 4;
    localparam int FRAME_LOW = (2 * WORD_W + 1) * SCLK_DIV;
    localparam int RUN_BUDGET = 3000;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              locked;
    logic              start;
    logic [1:0]        cfg_addr;
    logic [WORD_W-1:0] cfg_data;
    logic              spi_csn, spi_sclk, spi_sdata;
    logic              busy, init_done, err;

    int total = 0;
    int bad   = 0;

    always #50 sys_clk = ~sys_clk;

    adc_spi_init #(
        .WORD_W(WORD_W), .NUM_REGS(NUM_REGS), .SCLK_DIV(SCLK_DIV),
        .LOCK_WAIT(LOCK_WAIT), .CS_GAP(CS_GAP)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .locked(locked), .start(start),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_sdata(spi_sdata),
        .busy(busy), .init_done(init_done), .err(err)
    );

    // Synchronous config ROM: data valid one cycle after the address.
    logic [WORD_W-1:0] rom [NUM_REGS];
    always @(posedge sys_clk) cfg_data <= rom[cfg_addr];

    // ADC-side reference: samples the bus each cycle and reassembles frames.
    typedef struct {
        logic [WORD_W-1:0] word;
        int                edges;
        int                low;
    } frame_t;

    frame_t            fq[$];
    logic              mon_en = 1'b0;
    logic [WORD_W-1:0] mon_sh = '0;
    int                mon_edges = 0;
    int                mon_low = 0;
    int                viol = 0;
    logic              p_csn = 1'b1, p_sclk = 1'b0, p_sdata = 1'b0;

    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (spi_csn === 1'b0) begin
                if (p_csn) begin
                    mon_low = 1; mon_edges = 0; mon_sh = '0;
                end else begin
                    mon_low++;
                    if (spi_sdata !== p_sdata && !(p_sclk && !spi_sclk))
                        viol++;
                end
                if (spi_sclk && !p_sclk) begin
                    mon_sh = {mon_sh[WORD_W-2:0], spi_sdata};
                    mon_edges++;
                end
            end else begin
                if (!p_csn)
                    fq.push_back('{word: mon_sh, edges: mon_edges, low: mon_low});
                if (spi_sdata !== 1'b0 || spi_sclk !== 1'b0)
                    viol++;
            end
            p_csn = spi_csn; p_sclk = spi_sclk; p_sdata = spi_sdata;
        end
    end

    typedef struct {
        logic [0:NUM_REGS-1][WORD_W-1:0] w;
        int                              exp_low;
        int                              exp_edges;
        logic                            exp_err;
    } vec_t;

    task automatic step();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk(nm, {spi_csn, spi_sclk, spi_sdata, cfg_addr, busy, init_done, err},
                {1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic load_rom(input logic [0:NUM_REGS-1][WORD_W-1:0] w);
        for (int i = 0; i < NUM_REGS; i++) rom[i] = w[i];
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Steps until spi_csn falls; n is the number of edges taken.
    task automatic csn_latency(output int n);
        n = 0;
        while (spi_csn === 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    // Expected: every table entry arrives in order as a complete frame, then DONE.
    task automatic check_run(input logic [0:NUM_REGS-1][WORD_W-1:0] w, input int elow,
                             input int eedges, input logic eerr, input string tag);
        int k = 0;
        while ((fq.size() < NUM_REGS || init_done !== 1'b1) && k < RUN_BUDGET) begin
            step();
            k++;
        end
        chk({tag, "_frames"}, fq.size(), NUM_REGS);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i < fq.size()) begin
                chk($sformatf("%s_word%0d", tag, i), fq[i].word, w[i]);
                chk($sformatf("%s_edges%0d", tag, i), fq[i].edges, eedges);
                chk($sformatf("%s_low%0d", tag, i), fq[i].low, elow);
            end
        end
        chk({tag, "_done"}, init_done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err"}, err, eerr);
        fq.delete();
    endtask

    initial begin
        vec_t                            tbl[4];
        logic [0:NUM_REGS-1][WORD_W-1:0] rw;
        int                              n;
        int                              k;

        tbl[0] = '{w: {24'h0123AB, 24'h800001, 24'hFFFFFF, 24'h000000},
                   exp_low: FRAME_LOW, exp_edges: WORD_W, exp_err: 1'b0};
        tbl[1] = '{w: {24'hAAAAAA, 24'h555555, 24'h000001, 24'h800000},
                   exp_low: FRAME_LOW, exp_edges: WORD_W, exp_err: 1'b0};
        tbl[2] = '{w: {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF},
                   exp_low: FRAME_LOW, exp_edges: WORD_W, exp_err: 1'b0};
        tbl[3] = '{w: {24'h123456, 24'h789ABC, 24'hDEF012, 24'h0F0F0F},
                   exp_low: FRAME_LOW, exp_edges: WORD_W, exp_err: 1'b0};

        sys_rst = 1'b1; locked = 1'b0; start = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) rom[i] = '0;
        repeat (3) step();
        chk_reset_outputs("reset_state");
        mon_en  = 1'b1;
        sys_rst = 1'b0;
        repeat (5) step();
        chk("idle_no_lock_busy", busy, 1'b0);

        // Lock rises from IDLE: one cycle to leave IDLE, LOCK_WAIT to qualify,
        // two for the ROM fetch, then chip select drops.
        load_rom(tbl[0].w);
        locked = 1'b1;
        csn_latency(n);
        chk("lock_latency", n, LOCK_WAIT + 3);
        check_run(tbl[0].w, tbl[0].exp_low, tbl[0].exp_edges, tbl[0].exp_err, "vec0");

        for (int v = 1; v < 4; v++) begin
            load_rom(tbl[v].w);
            pulse_start();
            chk($sformatf("vec%0d_start_clears_done", v), init_done, 1'b0);
            chk($sformatf("vec%0d_start_sets_busy", v), busy, 1'b1);
            check_run(tbl[v].w, tbl[v].exp_low, tbl[v].exp_edges, tbl[v].exp_err,
                      $sformatf("vec%0d", v));
        end

        // Random tables, each with a stray start pulse while a word is shifting.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NUM_REGS; i++) rw[i] = WORD_W'($urandom);
            load_rom(rw);
            pulse_start();
            repeat ($urandom_range(30, 300)) step();
            k = 0;
            while (spi_csn !== 1'b0 && k < 200) begin step(); k++; end
            pulse_start();
            check_run(rw, FRAME_LOW, WORD_W, 1'b0, $sformatf("rnd%0d", r));
        end

        // Lock loss at bit 10 of word 1, then relock and resend from word 0.
        load_rom(tbl[0].w);
        pulse_start();
        k = 0;
        while (!(fq.size() == 1 && spi_csn === 1'b0 && mon_edges == 10) && k < RUN_BUDGET) begin
            step(); k++;
        end
        chk("lockloss_reached_bit10", mon_edges, 10);
        locked = 1'b0;
        step();
        chk("lockloss_csn", spi_csn, 1'b1);
        chk("lockloss_sclk", spi_sclk, 1'b0);
        chk("lockloss_err", err, 1'b1);
        chk("lockloss_addr", cfg_addr, 2'd0);
        repeat (5) step();
        fq.delete();
        locked = 1'b1;
        check_run(tbl[0].w, FRAME_LOW, WORD_W, 1'b1, "relock");
        pulse_start();
        chk("start_clears_err", err, 1'b0);
        check_run(tbl[0].w, FRAME_LOW, WORD_W, 1'b0, "after_err");

        // One-cycle lock glitch when the qualification count has reached 15.
        sys_rst = 1'b1; locked = 1'b0;
        repeat (2) step();
        sys_rst = 1'b0;
        step();
        locked = 1'b1;
        repeat (LOCK_WAIT) step();
        chk("glitch_csn_still_high", spi_csn, 1'b1);
        locked = 1'b0;
        step();
        locked = 1'b1;
        csn_latency(n);
        chk("glitch_latency", n, LOCK_WAIT + 2);
        check_run(tbl[0].w, FRAME_LOW, WORD_W, 1'b0, "glitch");

        // Reset in the middle of word 2.
        load_rom(tbl[1].w);
        pulse_start();
        k = 0;
        while (!(fq.size() == 2 && spi_csn === 1'b0 && mon_edges >= 6) && k < RUN_BUDGET) begin
            step(); k++;
        end
        chk("midreset_reached_word2", fq.size(), 2);
        sys_rst = 1'b1;
        step();
        chk_reset_outputs("midreset_outputs");
        sys_rst = 1'b0;
        step();
        fq.delete();
        check_run(tbl[1].w, FRAME_LOW, WORD_W, 1'b0, "after_reset");

        chk("protocol_violations", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
